// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants for the ID-stage hazard controller.
// Holds the mult/div tracker state encoding, the zero-register index and the default latency.
package hazard_stall_unit_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LAT_DEFAULT = 4;

endpackage

// File: rtl/hazard_stall_unit_md_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit from its issue pulse.
// state   | meaning
// MD_IDLE | unit free, waiting for an issue pulse
// MD_BUSY | operation in flight, counter counts down to the last busy cycle
module md_tracker
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = $clog2(MD_LAT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Both outputs decode flops only, so reset clears them without waiting for an edge.
  assign busy = (state_q == MD_BUSY);
  assign done = (state_q == MD_BUSY) && (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use and mult/div stalls, taken-branch flush,
// mult/div issue and a saturating stall-cycle counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = $clog2(MD_LAT),
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_Ra,
  input  logic [4:0]        id_Rb,
  input  logic              id_useRa,
  input  logic              id_useRb,
  input  logic              id_isMD,
  input  logic              id_useHiLo,
  input  logic              ex_MemRd,
  input  logic [4:0]        ex_Rw,
  input  logic              ex_branchTaken,
  output logic              pc_wr,
  output logic              ifid_wr,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_count
);

  logic              load_use;
  logic              md_hazard;
  logic              stall;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    load_use  = ex_MemRd && (ex_Rw != REG_ZERO) &&
                ((id_useRa && (ex_Rw == id_Ra)) || (id_useRb && (ex_Rw == id_Rb)));
    md_hazard = md_busy && (id_isMD || id_useHiLo);
    // A taken branch discards the ID instruction, so its hazards no longer matter.
    stall     = (load_use || md_hazard) && !ex_branchTaken;
    md_start  = id_isMD && !md_busy && !load_use && !ex_branchTaken;
  end

  assign pc_wr      = !stall;
  assign ifid_wr    = !stall;
  assign idex_flush = stall || ex_branchTaken;
  assign ifid_flush = ex_branchTaken;

  md_tracker #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .busy  (md_busy),
    .done  (md_done)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
